sysmon_drp_master: RTL and testbench
====================================

Name: sysmon_drp_master

Overview:
- PicoBus-controlled initiator for the SYSMON Dynamic Reconfiguration Port (DRP).
- Software posts single-register write or read commands, e.g. alarm limits 0x50-0x57 or config registers 0x40-0x42. The block issues the one-cycle DEN/DWE transaction and waits for DRDY.
- It latches read data or flags a timeout, and exposes the result on PicoBus status.
- Sits beside the sensor-readout logic as the DRP master used for runtime reconfiguration.

Parameters:
- BASE_ADDR, 32'h0, PicoBus base address; command at BASE_ADDR, status at BASE_ADDR+4.
- TIMEOUT, 64, max PicoClk cycles to wait for drp_drdy after DEN; must be 2..255.

Ports:
- PicoClk  in  1  sole clock; PicoBus and DRP (drp_dclk) both run on it.
- PicoRst_n  in  1  asynchronous, active-low reset.
- PicoAddr  in  32  PicoBus address.
- PicoDataIn  in  32  PicoBus write data.
- PicoWr  in  1  PicoBus write strobe.
- PicoRd  in  1  PicoBus read strobe.
- PicoDataOut  out  32  PicoBus read data, registered.
- drp_den  out  1  DRP enable, single-cycle pulse.
- drp_dwe  out  1  DRP write enable, valid with drp_den.
- drp_daddr  out  7  DRP register address.
- drp_di  out  16  DRP write data.
- drp_do  in  16  DRP read data, valid when drp_drdy is high.
- drp_drdy  in  1  DRP transaction complete.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, rdata=0, all flags 0, timeout counter 0.
- Command register (write BASE_ADDR): bit31 = 1 for write, 0 for read; bits22:16 = daddr; bits15:0 = wdata. All other bits are ignored.
- Command accept:
  - Accepted only when the FSM is IDLE. It is captured into cmd_wr, cmd_addr and cmd_data, and the FSM moves to ISSUE on the next edge.
  - A command write while not IDLE is dropped and sets sticky overflow.
- FSM states:
  - IDLE: busy=0.
  - ISSUE: exactly one cycle. Drives drp_den=1, drp_dwe=cmd_wr, drp_daddr=cmd_addr, drp_di=cmd_data. Goes to WAIT.
  - WAIT:
    - drp_den=0 and drp_dwe=0; drp_daddr and drp_di hold their values.
    - The counter increments each cycle.
    - If drp_drdy=1: latch drp_do into rdata (read commands only; writes leave rdata unchanged), clear timeout for this op, go to IDLE.
    - Else if counter reaches TIMEOUT-1: set sticky timeout, go to IDLE.
    - drp_drdy and the final count in the same cycle: drdy wins, no timeout.
- Counter: 8 bits, cleared on entry to ISSUE.
- Latency: command write edge N → DEN at cycle N+1 → earliest return to IDLE at N+2 (drdy at N+2). busy is visible from N+1.
- drp_drdy outside WAIT is ignored; no state or data change.
- Status register (read BASE_ADDR+4): bit31 busy, bit30 timeout, bit29 overflow, bit28 last op was write, bits22:16 last daddr, bits15:0 rdata, other bits 0.
- Sticky flags are cleared by a read of BASE_ADDR+4. The returned value shows the pre-clear flags. If a set and a clear land on the same edge, set wins.
- PicoDataOut:
  - Registered, one cycle after PicoRd.
  - Read of BASE_ADDR returns the last accepted command word.
  - Reads of unmatched addresses, and cycles with no read, give 0.
- PicoWr and PicoRd in the same cycle are handled independently.
- Reset asserted mid-transaction: FSM returns to IDLE immediately and outputs clear asynchronously. An in-flight DRP op is abandoned, and a later stray drdy is ignored.

Decomposition:
- Shared package sysmon_pkg:
  - DRP register address constants: CFG0=7'h40, CFG1=7'h41, CFG2=7'h42, SEQ0=7'h48, ALM0..ALM7=7'h50..7'h57.
  - Command and status bit-position constants.
  - FSM state encoding: IDLE, ISSUE, WAIT.
- One natural sub-module, drp_txn_fsm: ISSUE/WAIT/timeout engine with a cmd in and a done/timeout/rdata out. The PicoBus register decode stays in the top level.

Test Plan:
- Write: write BASE_ADDR=32'h8053_B883, drdy 3 cycles after DEN → one DEN pulse with dwe=1, daddr=7'h53, di=16'hB883. Status afterwards = 32'h1053_xxxx with busy=0, timeout=0, bit28=1.
- Read: write 32'h0041_0000, drdy with drp_do=16'h20FE on the 2nd WAIT cycle → dwe=0, daddr=7'h41. Status read = 32'h0041_20FE.
- Timeout: read command with drdy never asserted → busy stays high for TIMEOUT+1 cycles. Status bit30=1, rdata unchanged. A second status read shows bit30=0.
- Overflow: second command written while busy → no second DEN pulse. Status bit29=1, and the first op completes normally.
- drdy on the final count cycle (TIMEOUT=4, drdy at WAIT cycle 4) → rdata latched, timeout=0. A stray drdy while IDLE changes nothing.
- Assert PicoRst_n low during WAIT → all outputs 0 asynchronously. After release, a new command issues normally and a late drdy is ignored.

Source files
------------

// File: rtl/sysmon_pkg.sv
// sysmon_pkg: shared DRP register addresses, PicoBus bit positions and DRP FSM states
package sysmon_pkg;
  localparam logic [6:0] CFG0 = 7'h40;
  localparam logic [6:0] CFG1 = 7'h41;
  localparam logic [6:0] CFG2 = 7'h42;
  localparam logic [6:0] SEQ0 = 7'h48;
  localparam logic [6:0] ALM0 = 7'h50;
  localparam logic [6:0] ALM1 = 7'h51;
  localparam logic [6:0] ALM2 = 7'h52;
  localparam logic [6:0] ALM3 = 7'h53;
  localparam logic [6:0] ALM4 = 7'h54;
  localparam logic [6:0] ALM5 = 7'h55;
  localparam logic [6:0] ALM6 = 7'h56;
  localparam logic [6:0] ALM7 = 7'h57;
  localparam int CMD_WR       = 31;
  localparam int CMD_ADDR_MSB = 22;
  localparam int CMD_ADDR_LSB = 16;
  localparam int ST_BUSY      = 31;
  localparam int ST_TIMEOUT   = 30;
  localparam int ST_OVERFLOW  = 29;
  localparam int ST_WRITE     = 28;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} drp_state_t;
endpackage

// File: rtl/sysmon_drp_master_drp_txn_fsm.sv
// drp_txn_fsm: issues one DEN/DWE transaction, waits for DRDY or times out, latches read data
module drp_txn_fsm
  import sysmon_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        PicoClk,
  input  logic        PicoRst_n,
  input  logic        start,
  input  logic        cmd_wr,
  input  logic [6:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  output logic        busy,
  output logic        timeout,
  output logic [15:0] rdata
);
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  drp_state_t state, state_n;
  logic [7:0] cnt;
  assign drp_den   = state == ISSUE;
  assign drp_dwe   = drp_den && cmd_wr;
  assign drp_daddr = cmd_addr;
  assign drp_di    = cmd_data;
  assign busy      = state != IDLE;
  // state, wait counter (zeroed entering ISSUE) and read-data capture on DRDY
  always_ff @(posedge PicoClk or negedge PicoRst_n) begin
    if (!PicoRst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rdata <= '0;
    end else begin
      state <= state_n;
      cnt   <= state_n == ISSUE ? 8'd0 : state == WAIT ? cnt + 8'd1 : cnt;
      if (state == WAIT && drp_drdy && !cmd_wr) rdata <= drp_do;
    end
  end
  // next state; DRDY takes priority over the final count so a late-but-valid reply is not a timeout
  always_comb begin
    state_n = state;
    timeout = 1'b0;
    case (state)
      IDLE:  state_n = start ? ISSUE : IDLE;
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (drp_drdy) state_n = IDLE;
        else if (cnt == LAST) begin
          timeout = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: rtl/sysmon_drp_master.sv
// sysmon_drp_master: PicoBus command/status front end driving the SYSMON DRP
module sysmon_drp_master
  import sysmon_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          TIMEOUT   = 64
) (
  input  logic        PicoClk,
  input  logic        PicoRst_n,
  input  logic [31:0] PicoAddr,
  input  logic [31:0] PicoDataIn,
  input  logic        PicoWr,
  input  logic        PicoRd,
  output logic [31:0] PicoDataOut,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy
);
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
  logic [31:0] cmd_word, status;
  logic [15:0] rdata;
  logic busy, txn_timeout, timeout_flag, overflow_flag, cmd_hit, stat_hit, accept;
  assign cmd_hit  = PicoWr && PicoAddr == BASE_ADDR;
  assign accept   = cmd_hit && !busy;
  assign stat_hit = PicoRd && PicoAddr == STATUS_ADDR;
  // status word as seen before this cycle's clear-on-read
  always_comb begin
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_TIMEOUT] = timeout_flag;
    status[ST_OVERFLOW] = overflow_flag;
    status[ST_WRITE] = cmd_word[CMD_WR];
    status[CMD_ADDR_MSB:CMD_ADDR_LSB] = cmd_word[CMD_ADDR_MSB:CMD_ADDR_LSB];
    status[15:0] = rdata;
  end
  // command capture, sticky flags (set beats clear) and registered read data
  always_ff @(posedge PicoClk or negedge PicoRst_n) begin
    if (!PicoRst_n) begin
      cmd_word      <= '0;
      timeout_flag  <= 1'b0;
      overflow_flag <= 1'b0;
      PicoDataOut   <= '0;
    end else begin
      if (accept) cmd_word <= PicoDataIn;
      timeout_flag  <= txn_timeout || (timeout_flag && !stat_hit);
      overflow_flag <= (cmd_hit && busy) || (overflow_flag && !stat_hit);
      PicoDataOut   <= stat_hit ? status : (PicoRd && PicoAddr == BASE_ADDR) ? cmd_word : '0;
    end
  end
  drp_txn_fsm #(.TIMEOUT(TIMEOUT)) u_txn (
    .PicoClk   (PicoClk),
    .PicoRst_n (PicoRst_n),
    .start     (accept),
    .cmd_wr    (cmd_word[CMD_WR]),
    .cmd_addr  (cmd_word[CMD_ADDR_MSB:CMD_ADDR_LSB]),
    .cmd_data  (cmd_word[15:0]),
    .drp_do    (drp_do),
    .drp_drdy  (drp_drdy),
    .drp_den   (drp_den),
    .drp_dwe   (drp_dwe),
    .drp_daddr (drp_daddr),
    .drp_di    (drp_di),
    .busy      (busy),
    .timeout   (txn_timeout),
    .rdata     (rdata)
  );
endmodule

// File: tb/tb_sysmon_drp_master.sv
// tb_sysmon_drp_master: directed and randomized bench against a transaction-level model
module tb_sysmon_drp_master;
  localparam logic [31:0] BASE = 32'h4000_0100;
  localparam logic [31:0] STAT = BASE + 32'd4;
  localparam int TO = 4;
  logic PicoClk, PicoRst_n, PicoWr, PicoRd;
  logic [31:0] PicoAddr, PicoDataIn, PicoDataOut;
  logic drp_den, drp_dwe, drp_drdy;
  logic [6:0] drp_daddr;
  logic [15:0] drp_di, drp_do;
  logic r_drdy, s_drdy;
  logic [15:0] r_do, s_do, resp_do;
  int resp_k;
  int checks = 0, errors = 0;
  bit m_busy, m_to, m_ovf;
  logic [31:0] m_cmd, m_dout;
  logic [15:0] m_rdata;
  int ecnt, m_e0;
  assign drp_drdy = r_drdy | s_drdy;
  assign drp_do = r_drdy ? r_do : s_do;
  sysmon_drp_master #(.BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
    .PicoClk(PicoClk), .PicoRst_n(PicoRst_n), .PicoAddr(PicoAddr), .PicoDataIn(PicoDataIn),
    .PicoWr(PicoWr), .PicoRd(PicoRd), .PicoDataOut(PicoDataOut), .drp_den(drp_den),
    .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_do(drp_do), .drp_drdy(drp_drdy)
  );
  initial PicoClk = 1'b0;
  always #5 PicoClk = ~PicoClk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // transaction-level model: one op at a time, DEN the cycle after acceptance, done on DRDY or after TO wait cycles
  always @(posedge PicoClk or negedge PicoRst_n) begin : model
    logic [31:0] st;
    bit was_busy, to_set, ovf_set, rd_st;
    int k;
    if (!PicoRst_n) begin
      m_busy = 0; m_to = 0; m_ovf = 0; m_cmd = '0; m_rdata = '0; m_dout = '0; ecnt = 0; m_e0 = 0;
    end else begin
      ecnt++;
      st = {m_busy, m_to, m_ovf, m_cmd[31], 5'b0, m_cmd[22:16], m_rdata};
      rd_st = PicoRd && PicoAddr == STAT;
      m_dout = !PicoRd ? 32'h0 : PicoAddr == BASE ? m_cmd : rd_st ? st : 32'h0;
      was_busy = m_busy; to_set = 0; ovf_set = 0;
      if (m_busy) begin
        k = ecnt - m_e0 - 1;
        if (k >= 1) begin
          if (drp_drdy) begin
            if (!m_cmd[31]) m_rdata = drp_do;
            m_busy = 0;
          end else if (k == TO) begin
            to_set = 1;
            m_busy = 0;
          end
        end
      end
      if (PicoWr && PicoAddr == BASE) begin
        if (was_busy) ovf_set = 1;
        else begin
          m_cmd = PicoDataIn; m_busy = 1; m_e0 = ecnt;
        end
      end
      m_to = to_set | (m_to & !rd_st);
      m_ovf = ovf_set | (m_ovf & !rd_st);
    end
  end
  // per-cycle comparison of DUT outputs against the model
  always @(negedge PicoClk) begin
    if (PicoRst_n) begin
      chk("den", drp_den, m_busy && ecnt == m_e0);
      chk("dwe", drp_dwe, m_busy && ecnt == m_e0 && m_cmd[31]);
      chk("dout", PicoDataOut, m_dout);
      if (m_busy) begin
        chk("daddr", drp_daddr, m_cmd[22:16]);
        chk("di", drp_di, m_cmd[15:0]);
      end
    end
  end
  // DRP slave: answers resp_k wait cycles after a DEN (0 = never answers)
  initial begin : responder
    int k;
    r_drdy = 0; r_do = '0;
    forever begin
      @(negedge PicoClk);
      if (drp_den && resp_k > 0) begin
        k = resp_k;
        repeat (k) @(posedge PicoClk);
        #1 r_drdy = 1; r_do = resp_do;
        @(posedge PicoClk);
        #1 r_drdy = 0;
      end
    end
  end
  task automatic step();
    @(posedge PicoClk); #1;
  endtask
  task automatic pico_wr(input logic [31:0] a, input logic [31:0] d);
    PicoWr = 1; PicoAddr = a; PicoDataIn = d;
    step();
    PicoWr = 0;
  endtask
  task automatic pico_rd(input logic [31:0] a, output logic [31:0] d);
    PicoRd = 1; PicoAddr = a;
    step();
    PicoRd = 0;
    d = PicoDataOut;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 50) begin step(); n++; end
    checks++;
    if (m_busy) begin
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles", n);
    end
  endtask
  initial begin
    logic [31:0] d;
    int n;
    PicoRst_n = 0; PicoWr = 0; PicoRd = 0; PicoAddr = '0; PicoDataIn = '0;
    s_drdy = 0; s_do = '0; resp_k = 0; resp_do = '0;
    #3;
    chk("rst_den", drp_den, 0); chk("rst_dwe", drp_dwe, 0); chk("rst_daddr", drp_daddr, 0);
    chk("rst_di", drp_di, 0); chk("rst_dout", PicoDataOut, 0);
    repeat (2) @(posedge PicoClk);
    #1 PicoRst_n = 1;
    pico_rd(STAT, d); chk("rst_status", d, 32'h0);
    resp_k = 3; resp_do = 16'hDEAD;
    pico_wr(BASE, 32'h8053_B883);
    chk("wr_den", drp_den, 1); chk("wr_dwe", drp_dwe, 1);
    chk("wr_daddr", drp_daddr, 7'h53); chk("wr_di", drp_di, 16'hB883);
    wait_idle();
    pico_rd(STAT, d); chk("wr_status", d, 32'h1053_0000);
    resp_k = 2; resp_do = 16'h20FE;
    pico_wr(BASE, 32'h0041_0000);
    chk("rd_den", drp_den, 1); chk("rd_dwe", drp_dwe, 0); chk("rd_daddr", drp_daddr, 7'h41);
    wait_idle();
    pico_rd(STAT, d); chk("rd_status", d, 32'h0041_20FE);
    resp_k = 0;
    pico_wr(BASE, 32'h0044_0000);
    n = 0;
    pico_rd(STAT, d);
    while (d[31] && n < 20) begin n++; pico_rd(STAT, d); end
    chk("to_busy_cycles", n, TO + 1);
    chk("to_flag_set", d[30], 1); chk("to_rdata_kept", d[15:0], 16'h20FE);
    pico_rd(STAT, d); chk("to_flag_cleared", d[30], 0);
    resp_k = 3; resp_do = 16'h0BAD;
    pico_wr(BASE, 32'h0050_0000);
    pico_wr(BASE, 32'h8057_1111);
    chk("ovf_no_den", drp_den, 0);
    wait_idle();
    pico_rd(STAT, d); chk("ovf_status", d, 32'h2050_0BAD);
    pico_rd(BASE, d); chk("ovf_cmd_word", d, 32'h0050_0000);
    resp_k = TO; resp_do = 16'hA5C3;
    pico_wr(BASE, 32'h0042_0000);
    wait_idle();
    pico_rd(STAT, d); chk("last_cnt_status", d, 32'h0042_A5C3);
    s_do = 16'h1234; s_drdy = 1;
    step();
    s_drdy = 0;
    pico_rd(STAT, d); chk("stray_status", d, 32'h0042_A5C3);
    resp_k = 20; resp_do = 16'h7777;
    pico_wr(BASE, 32'h8048_5555);
    step();
    #2 PicoRst_n = 0;
    #1;
    chk("arst_den", drp_den, 0); chk("arst_dwe", drp_dwe, 0); chk("arst_daddr", drp_daddr, 0);
    chk("arst_di", drp_di, 0); chk("arst_dout", PicoDataOut, 0);
    #10;
    @(posedge PicoClk);
    #1 PicoRst_n = 1;
    pico_rd(STAT, d); chk("arst_status", d, 32'h0);
    pico_wr(BASE, 32'h0040_0000);
    chk("post_rst_den", drp_den, 1); chk("post_rst_daddr", drp_daddr, 7'h40);
    repeat (25) step();
    pico_rd(STAT, d); chk("late_drdy_ignored", d, 32'h4040_0000);
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = $urandom_range(0, 5);
      PicoWr = $urandom_range(0, 3) == 0;
      PicoRd = $urandom_range(0, 2) == 0;
      PicoAddr = sel < 2 ? BASE : sel < 4 ? STAT : $urandom;
      PicoDataIn = $urandom;
      resp_k = $urandom_range(0, 6);
      resp_do = 16'($urandom);
      s_drdy = $urandom_range(0, 15) == 0;
      s_do = 16'($urandom);
      step();
    end
    PicoWr = 0; PicoRd = 0; s_drdy = 0; resp_k = 0;
    wait_idle();
    repeat (10) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
